// File: rtl/matrix_pkg.sv
// Shared state encoding, default sizes and a one-hot helper for the round controller.
package matrix_pkg;

   localparam int unsigned TILES_DEFAULT   = 8;
   localparam int unsigned GUESS_W_DEFAULT = 4;

   // Encoding is visible on state_o, so the order here is part of the interface.
   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StStartWait = 3'd1,
      StShow      = 3'd2,
      StPlay      = 3'd3,
      StCheck     = 3'd4,
      StWin       = 3'd5,
      StLose      = 3'd6,
      StEndWait   = 3'd7
   } state_e;

   // True when exactly one bit of v is set.
   function automatic logic is_one_hot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/matrix_round_ctrl_if.sv
// Player-facing signal bundle of the round controller.
interface matrix_round_ctrl_if
   import matrix_pkg::*;
#(
   parameter int unsigned TILES   = TILES_DEFAULT,
   parameter int unsigned GUESS_W = GUESS_W_DEFAULT
) ();

   logic               start;
   logic [TILES-1:0]   solution;
   logic [GUESS_W-1:0] max_guesses;
   logic               guess_valid;
   logic [TILES-1:0]   guess;
   logic [TILES-1:0]   led;
   logic               status_led;
   logic [GUESS_W-1:0] guesses_left;
   logic [2:0]         state_o;
   logic               win;
   logic               lose;

   modport master (
      output start, solution, max_guesses, guess_valid, guess,
      input  led, status_led, guesses_left, state_o, win, lose
   );

   modport slave (
      input  start, solution, max_guesses, guess_valid, guess,
      output led, status_led, guesses_left, state_o, win, lose
   );

endinterface

// File: rtl/tick_divider.sv
// Reloadable down-counter; tc pulses for one cycle every CYCLES enabled cycles.
module tick_divider #(
   parameter int unsigned CYCLES = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic reload,
   output logic tc
);

   localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CNT_W-1:0] LOAD = CNT_W'(CYCLES - 1);

   logic [CNT_W-1:0] count_q, count_d;

   assign tc = enable && (count_q == '0);

   // Reload wins over counting; wrap back to LOAD on terminal count.
   always_comb begin
      count_d = count_q;
      if (reload) begin
         count_d = LOAD;
      end else if (enable) begin
         count_d = (count_q == '0) ? LOAD : count_q - CNT_W'(1);
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/matrix_round_ctrl.sv
// Round controller for the tile memory game: show solution, take guesses, report win/lose.
module matrix_round_ctrl
   import matrix_pkg::*;
#(
   parameter int unsigned TILES          = TILES_DEFAULT,
   parameter int unsigned GUESS_W        = GUESS_W_DEFAULT,
   parameter int unsigned DISPLAY_CYCLES = 50_000_000,
   parameter int unsigned FLASH_CYCLES   = 12_500_000
) (
   input logic                 clk,
   input logic                 reset,
   matrix_round_ctrl_if.slave  bus
);

   state_e             state_q, state_d;
   logic [TILES-1:0]   sol_q, sol_d;
   logic [TILES-1:0]   found_q, found_d;
   logic [TILES-1:0]   led_q, led_d;
   logic [GUESS_W-1:0] left_q, left_d;
   logic               phase_q, phase_d;
   logic               status_q, status_d;
   logic               win_q, win_d;
   logic               lose_q, lose_d;

   logic show_run, show_tc;
   logic flash_run, flash_tc;

   assign show_run  = (state_q == StShow);
   assign flash_run = (state_q == StIdle) || (state_q == StLose);

   // Timers are held at their reload value outside their states, so every entry starts fresh.
   tick_divider #(
      .CYCLES (DISPLAY_CYCLES)
   ) u_show_timer (
      .clk    (clk),
      .reset  (reset),
      .enable (show_run),
      .reload (!show_run),
      .tc     (show_tc)
   );

   tick_divider #(
      .CYCLES (FLASH_CYCLES)
   ) u_flash_timer (
      .clk    (clk),
      .reset  (reset),
      .enable (flash_run),
      .reload (!flash_run),
      .tc     (flash_tc)
   );

   // Next-state logic plus next values of the registered outputs.
   always_comb begin
      state_d = state_q;
      sol_d   = sol_q;
      found_d = found_q;
      left_d  = left_q;
      phase_d = flash_run ? (phase_q ^ flash_tc) : 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StStartWait;
               sol_d   = bus.solution;
               left_d  = (bus.max_guesses == '0) ? GUESS_W'(1) : bus.max_guesses;
               found_d = '0;
            end
         end
         StStartWait: if (!bus.start) state_d = StShow;
         StShow: begin
            if (show_tc) state_d = (sol_q == '0) ? StWin : StPlay;
         end
         StPlay: begin
            if (bus.guess_valid && is_one_hot(32'(bus.guess))) begin
               // A repeat hit ORs in an already-set bit and costs nothing.
               if ((bus.guess & sol_q) != '0) begin
                  found_d = found_q | bus.guess;
               end else if (left_q != '0) begin
                  left_d = left_q - GUESS_W'(1);
               end
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (found_q == sol_q)    state_d = StWin;
            else if (left_q == '0)   state_d = StLose;
            else                     state_d = StPlay;
         end
         StWin, StLose: if (bus.start) state_d = StEndWait;
         StEndWait: if (!bus.start) state_d = StIdle;
         default: state_d = StIdle;
      endcase

      led_d    = '0;
      status_d = 1'b0;
      win_d    = 1'b0;
      lose_d   = 1'b0;
      unique case (state_d)
         StIdle:          status_d = phase_d;
         StShow:          led_d    = sol_d;
         StPlay, StCheck: led_d    = found_d;
         StWin: begin
            led_d    = sol_d;
            status_d = 1'b1;
            win_d    = 1'b1;
         end
         StLose: begin
            led_d    = sol_d & {TILES{phase_d}};
            status_d = phase_d;
            lose_d   = 1'b1;
         end
         default: ;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= StIdle;
         sol_q    <= '0;
         found_q  <= '0;
         left_q   <= '0;
         phase_q  <= 1'b0;
         led_q    <= '0;
         status_q <= 1'b0;
         win_q    <= 1'b0;
         lose_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sol_q    <= sol_d;
         found_q  <= found_d;
         left_q   <= left_d;
         phase_q  <= phase_d;
         led_q    <= led_d;
         status_q <= status_d;
         win_q    <= win_d;
         lose_q   <= lose_d;
      end
   end

   assign bus.led          = led_q;
   assign bus.status_led   = status_q;
   assign bus.guesses_left = left_q;
   assign bus.state_o      = state_q;
   assign bus.win          = win_q;
   assign bus.lose         = lose_q;

endmodule

// File: tb/tb_matrix_round_ctrl.sv
// Randomized bench for matrix_round_ctrl with a round-level reference model.
module tb_matrix_round_ctrl;

   localparam int TILES   = 8;
   localparam int GUESS_W = 4;
   localparam int DC      = 4;
   localparam int FC      = 2;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_SHOW  = 3'd2;
   localparam logic [2:0] S_PLAY  = 3'd3;
   localparam logic [2:0] S_CHECK = 3'd4;
   localparam logic [2:0] S_WIN   = 3'd5;
   localparam logic [2:0] S_LOSE  = 3'd6;
   localparam logic [2:0] S_END   = 3'd7;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   matrix_round_ctrl_if #(.TILES(TILES), .GUESS_W(GUESS_W)) bus ();

   matrix_round_ctrl #(
      .TILES          (TILES),
      .GUESS_W        (GUESS_W),
      .DISPLAY_CYCLES (DC),
      .FLASH_CYCLES   (FC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] guess_q[$];
   logic [7:0] m_sol;
   logic [7:0] m_found;
   int         m_left;
   int         m_result;   // 0 running, 1 won, 2 lost

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, " state"}, 32'(bus.state_o), 32'(S_IDLE));
      check_eq({tag, " led"}, 32'(bus.led), 32'h0);
      check_eq({tag, " status"}, 32'(bus.status_led), 32'h0);
      check_eq({tag, " left"}, 32'(bus.guesses_left), 32'h0);
      check_eq({tag, " win"}, 32'(bus.win), 32'h0);
      check_eq({tag, " lose"}, 32'(bus.lose), 32'h0);
   endtask

   task automatic apply_guess(input logic [7:0] g);
      logic [2:0] exp_st;
      logic [7:0] exp_led;
      bus.guess       = g;
      bus.guess_valid = 1'b1;
      step();
      bus.guess_valid = 1'b0;
      bus.guess       = 8'($urandom);
      if ($countones(g) == 1) begin
         if ((g & m_sol) != 8'h0) m_found = m_found | g;
         else if (m_left > 0)     m_left--;
         check_eq("guess state", 32'(bus.state_o), 32'(S_CHECK));
         check_eq("guess led", 32'(bus.led), 32'(m_found));
         check_eq("guess left", 32'(bus.guesses_left), 32'(m_left));
         check_eq("guess win early", 32'(bus.win), 32'h0);
         step();
         if (m_found == m_sol)  m_result = 1;
         else if (m_left == 0)  m_result = 2;
         exp_st  = (m_result == 1) ? S_WIN : (m_result == 2) ? S_LOSE : S_PLAY;
         exp_led = (m_result == 1) ? m_sol : (m_result == 2) ? 8'h00 : m_found;
         check_eq("result state", 32'(bus.state_o), 32'(exp_st));
         check_eq("result win", 32'(bus.win), 32'(m_result == 1));
         check_eq("result lose", 32'(bus.lose), 32'(m_result == 2));
         check_eq("result led", 32'(bus.led), 32'(exp_led));
      end else begin
         check_eq("ignored state", 32'(bus.state_o), 32'(S_PLAY));
         check_eq("ignored led", 32'(bus.led), 32'(m_found));
         check_eq("ignored left", 32'(bus.guesses_left), 32'(m_left));
      end
   endtask

   task automatic run_round(input logic [7:0] sol, input int mx);
      logic [7:0] g;
      m_sol    = sol;
      m_found  = 8'h0;
      m_left   = (mx == 0) ? 1 : mx;
      m_result = 0;

      bus.solution    = sol;
      bus.max_guesses = GUESS_W'(mx);
      bus.start       = 1'b1;
      step();
      check_eq("start_wait state", 32'(bus.state_o), 32'(S_START));
      check_eq("start_wait led", 32'(bus.led), 32'h0);
      // Inputs after the press must not affect the latched round.
      bus.solution    = ~sol;
      bus.max_guesses = GUESS_W'($urandom);
      bus.start       = 1'b0;
      step();

      for (int i = 0; i < DC; i++) begin
         check_eq("show state", 32'(bus.state_o), 32'(S_SHOW));
         check_eq("show led", 32'(bus.led), 32'(sol));
         check_eq("show left", 32'(bus.guesses_left), 32'(m_left));
         check_eq("show status", 32'(bus.status_led), 32'h0);
         bus.guess_valid = (i == 1);
         bus.guess       = (sol != 8'h0) ? (sol & (~sol + 8'h1)) : 8'h01;
         step();
         bus.guess_valid = 1'b0;
      end

      if (sol == 8'h0) begin
         m_result = 1;
         check_eq("zero sol state", 32'(bus.state_o), 32'(S_WIN));
         check_eq("zero sol win", 32'(bus.win), 32'h1);
      end else begin
         check_eq("play entry state", 32'(bus.state_o), 32'(S_PLAY));
         check_eq("play entry led", 32'(bus.led), 32'h0);
         check_eq("play entry left", 32'(bus.guesses_left), 32'(m_left));
      end

      while (m_result == 0 && guess_q.size() > 0) begin
         g = guess_q.pop_front();
         apply_guess(g);
      end
      if (m_result == 0) return;

      if (m_result == 2) begin
         for (int t = 0; t < 4 * FC; t++) begin
            check_eq("lose led", 32'(bus.led), ((t / FC) % 2 == 1) ? 32'(sol) : 32'h0);
            check_eq("lose status", 32'(bus.status_led), 32'((t / FC) % 2));
            check_eq("lose level", 32'(bus.lose), 32'h1);
            check_eq("lose left", 32'(bus.guesses_left), 32'h0);
            step();
         end
      end else begin
         for (int t = 0; t < 3; t++) begin
            check_eq("win led", 32'(bus.led), 32'(sol));
            check_eq("win status", 32'(bus.status_led), 32'h1);
            check_eq("win level", 32'(bus.win), 32'h1);
            check_eq("win left", 32'(bus.guesses_left), 32'(m_left));
            step();
         end
      end

      bus.start = 1'b1;
      step();
      check_eq("end_wait state", 32'(bus.state_o), 32'(S_END));
      check_eq("end_wait led", 32'(bus.led), 32'h0);
      check_eq("end_wait win", 32'(bus.win), 32'h0);
      check_eq("end_wait lose", 32'(bus.lose), 32'h0);
      bus.start = 1'b0;
      step();
      for (int t = 0; t < 4 * FC; t++) begin
         check_eq("idle state", 32'(bus.state_o), 32'(S_IDLE));
         check_eq("idle led", 32'(bus.led), 32'h0);
         check_eq("idle status", 32'(bus.status_led), 32'((t / FC) % 2));
         step();
      end
   endtask

   function automatic logic [7:0] rand_guess();
      int k;
      k = $urandom_range(0, 9);
      if (k == 0)      return 8'h00;
      else if (k == 1) return 8'($urandom);
      else             return 8'h01 << $urandom_range(0, 7);
   endfunction

   initial begin
      logic [7:0] sol;
      bus.start       = 1'b0;
      bus.solution    = 8'h0;
      bus.max_guesses = '0;
      bus.guess_valid = 1'b0;
      bus.guess       = 8'h0;

      reset = 1'b0;
      step();
      step();
      check_all_zero("reset");
      reset = 1'b1;
      step();
      check_eq("post reset state", 32'(bus.state_o), 32'(S_IDLE));

      // Win with two hits, budget untouched.
      guess_q.delete();
      guess_q.push_back(8'h01);
      guess_q.push_back(8'h80);
      run_round(8'h81, 3);

      // Lose after two misses.
      guess_q.delete();
      guess_q.push_back(8'h02);
      guess_q.push_back(8'h04);
      run_round(8'h01, 2);

      // Illegal guesses, repeat hit, a miss, then completion.
      guess_q.delete();
      foreach (guess_q[i]) guess_q.delete(i);
      guess_q.push_back(8'h03);
      guess_q.push_back(8'h00);
      guess_q.push_back(8'h01);
      guess_q.push_back(8'h01);
      guess_q.push_back(8'h02);
      guess_q.push_back(8'hFF);
      guess_q.push_back(8'h20);
      guess_q.push_back(8'h04);
      guess_q.push_back(8'h80);
      run_round(8'hA5, 4);

      // Empty solution wins straight after SHOW; zero budget latches as 1.
      guess_q.delete();
      run_round(8'h00, 0);

      for (int r = 0; r < 25; r++) begin
         sol = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         guess_q.delete();
         for (int n = 0; n < 60; n++) guess_q.push_back(rand_guess());
         run_round(sol, $urandom_range(0, 15));
         if (m_result == 0) begin
            reset = 1'b0;
            step();
            check_all_zero("rand reset");
            reset = 1'b1;
            step();
         end
      end

      // Reset in the middle of PLAY.
      guess_q.delete();
      guess_q.push_back(8'h01);
      run_round(8'h81, 3);
      check_eq("mid play state", 32'(bus.state_o), 32'(S_PLAY));
      reset = 1'b0;
      step();
      check_all_zero("play reset");
      reset = 1'b1;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/matrix_round_ctrl.md
MATRIX_ROUND_CTRL -- requirements
Module: matrix_round_ctrl

Interface
REQ-001 Parameter TILES, default 8, number of board tiles and width of all tile vectors (legal range 2..32).
REQ-002 Parameter GUESS_W, default 4, width of guess counters.
REQ-003 Parameter DISPLAY_CYCLES, default 50_000_000, clk cycles the solution is shown (≥1).
REQ-004 Parameter FLASH_CYCLES, default 12_500_000, clk cycles per flash half-period (≥1).
REQ-005 clk  input  1  clock; reset, synchronous, active-low.
REQ-006 reset  input  1  synchronous active-low reset.
REQ-007 start  input  1  level start button (active-high, already inverted upstream).
REQ-008 solution  input  TILES  target tile mask, sampled on IDLE->START_WAIT.
REQ-009 max_guesses  input  GUESS_W  wrong-guess budget, sampled with solution.
REQ-010 guess_valid  input  1  single-cycle guess strobe.
REQ-011 guess  input  TILES  guessed tile, qualified by guess_valid.
REQ-012 led  output  TILES  tile LED drive.
REQ-013 status_led  output  1  flashing status LED.
REQ-014 guesses_left  output  GUESS_W  remaining wrong-guess budget.
REQ-015 state_o  output  3  current FSM state encoding.
REQ-016 win / lose  output  1 each  round result, level, held until leaving WIN/LOSE.

Function
REQ-017 FSM states: IDLE, START_WAIT, SHOW, PLAY, CHECK, WIN, LOSE, END_WAIT.
REQ-018 IDLE->START_WAIT on start=1; latch solution into sol_q and max_guesses into guesses_left (0 latched as 1); clear found mask.
REQ-019 START_WAIT->SHOW on start=0 (button release).
REQ-020 SHOW lasts exactly DISPLAY_CYCLES cycles, then ->PLAY; if sol_q==0, SHOW->WIN instead.
REQ-021 PLAY: guess_valid with guess not exactly one-hot (zero or ≥2 bits) is ignored, no state change.
REQ-022 PLAY, valid one-hot guess: hit (guess & sol_q & ~found)≠0 -> found|=guess; repeat hit on found tile -> no change, no penalty; miss (guess & sol_q)==0 -> guesses_left-=1; all cases ->CHECK next edge.
REQ-023 CHECK (1 cycle): found==sol_q -> WIN; else guesses_left==0 -> LOSE; else ->PLAY; win has priority.
REQ-024 guess_valid outside PLAY is ignored; guesses_left never wraps below 0.
REQ-025 WIN/LOSE -> END_WAIT on start=1; END_WAIT -> IDLE on start=0.
REQ-026 led: IDLE all 0; SHOW sol_q; PLAY/CHECK found; WIN sol_q steady; LOSE sol_q gated by flash phase; START_WAIT/END_WAIT 0.
REQ-027 status_led = flash phase in IDLE and LOSE, 1 in WIN, 0 otherwise.
REQ-028 Flash phase toggles every FLASH_CYCLES cycles, free-running while in IDLE/LOSE, reset to 0 on entry to each.
REQ-029 All outputs registered; guess-to-led/guesses_left latency 1 cycle; guess-to-win/lose latency 2 cycles.

Reset
REQ-030 reset=0 on clk edge: state IDLE, led 0, status_led 0, guesses_left 0, win 0, lose 0, found 0, sol_q 0, counters 0; overrides any in-flight SHOW, PLAY or CHECK.

Structure
REQ-031 Package matrix_pkg holds state encoding constants and default TILES/GUESS_W.
REQ-032 One sub-module tick_divider (parametrised down-counter, enable, reload, terminal-count pulse), instanced twice: SHOW timer and flash timer.

Verification (TILES=8, DISPLAY_CYCLES=4, FLASH_CYCLES=2)
REQ-033 solution=0x81, max_guesses=3, press/release start -> led=0x81 for exactly 4 cycles, then led=0x00, state PLAY.
REQ-034 PLAY, guess 0x01 then 0x80 -> led 0x01 then 0x81, win=1 two cycles after second strobe, guesses_left=3.
REQ-035 solution=0x01, max_guesses=2, guesses 0x02, 0x04 -> guesses_left 1 then 0, lose=1, led toggles 0x01/0x00 every 2 cycles.
REQ-036 guess 0x03 and 0x00 in PLAY, repeat of found tile -> no change to found or guesses_left.
REQ-037 solution=0x00 -> WIN directly after SHOW; max_guesses=0 -> guesses_left=1.
REQ-038 reset=0 during PLAY -> next cycle state IDLE, all outputs 0.
